// File: rtl/bcd_counter_multicode_if.sv
// bcd_counter_multicode_if: control, load and result bus of the multi-code decade counter
interface bcd_counter_multicode_if #(
    parameter int NDIGITS = 2
);
    logic                   i_en;
    logic                   i_up;
    logic                   i_load;
    logic [4*NDIGITS-1:0]   i_load_val;
    logic [1:0]             i_mode;
    logic [4*NDIGITS-1:0]   o_count;
    logic [4*NDIGITS-1:0]   o_out;
    logic                   o_wrap;
    logic                   o_load_err;

    modport master (
        output i_en, i_up, i_load, i_load_val, i_mode,
        input  o_count, o_out, o_wrap, o_load_err
    );

    modport slave (
        input  i_en, i_up, i_load, i_load_val, i_mode,
        output o_count, o_out, o_wrap, o_load_err
    );
endinterface

// File: rtl/bcd_counter_multicode.sv
// bcd_counter_multicode: N-digit up/down decade counter with loadable value and per-digit output code
module bcd_counter_multicode #(
    parameter int NDIGITS = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    bcd_counter_multicode_if.slave  bus
);
    localparam int W = 4 * NDIGITS;

    logic [W-1:0] r_count;
    logic [W-1:0] r_out;
    logic         r_wrap;
    logic         r_load_err;

    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;
    logic [W-1:0] w_ld;
    logic [W-1:0] w_next;
    logic         w_all9;
    logic         w_all0;
    logic         w_ld_bad;
    logic         w_wrap;

    // Encode every BCD digit into the selected code: 8421, 2421, 5421 or excess-3
    function automatic logic [W-1:0] f_enc(input logic [W-1:0] v, input logic [1:0] m);
        logic [W-1:0] e;
        logic [3:0]   d;
        e = v;
        for (int k = 0; k < NDIGITS; k++) begin
            d = v[4*k +: 4];
            e[4*k +: 4] = (m == 2'b00) ? d :
                          (m == 2'b01) ? ((d < 4'd5) ? d : d + 4'd6) :
                          (m == 2'b10) ? ((d < 4'd5) ? d : d + 4'd3) :
                                         d + 4'd3;
        end
        return e;
    endfunction

    // Ripple carry/borrow across digits and sanitise the load value, all in one cycle
    always_comb begin
        w_inc    = r_count;
        w_dec    = r_count;
        w_ld     = bus.i_load_val;
        w_all9   = 1'b1;
        w_all0   = 1'b1;
        w_ld_bad = 1'b0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (w_all9)
                w_inc[4*k +: 4] = (r_count[4*k +: 4] == 4'd9) ? 4'd0 : r_count[4*k +: 4] + 4'd1;
            if (w_all0)
                w_dec[4*k +: 4] = (r_count[4*k +: 4] == 4'd0) ? 4'd9 : r_count[4*k +: 4] - 4'd1;
            w_all9 = w_all9 & (r_count[4*k +: 4] == 4'd9);
            w_all0 = w_all0 & (r_count[4*k +: 4] == 4'd0);
            if (bus.i_load_val[4*k +: 4] > 4'd9) begin
                w_ld[4*k +: 4] = 4'd0;
                w_ld_bad       = 1'b1;
            end
        end
        w_next = bus.i_load ? w_ld : bus.i_en ? (bus.i_up ? w_inc : w_dec) : r_count;
        w_wrap = !bus.i_load & bus.i_en & (bus.i_up ? w_all9 : w_all0);
    end

    // Register count, encoded view and one-cycle flags; reset > load > count > hold
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= '0;
            r_out      <= f_enc('0, bus.i_mode);
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_out      <= f_enc(w_next, bus.i_mode);
            r_wrap     <= w_wrap;
            r_load_err <= bus.i_load & w_ld_bad;
        end
    end

    assign bus.o_count    = r_count;
    assign bus.o_out      = r_out;
    assign bus.o_wrap     = r_wrap;
    assign bus.o_load_err = r_load_err;
endmodule

// File: tb/tb_bcd_counter_multicode.sv
// tb_bcd_counter_multicode: directed plus randomized check against a decimal-integer reference model
module tb_bcd_counter_multicode;
    localparam int ND  = 2;
    localparam int W   = 4 * ND;
    localparam int MAX = 10 ** ND;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_counter_multicode_if #(.NDIGITS(ND)) bus ();

    bcd_counter_multicode #(.NDIGITS(ND)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    int         m_val  = 0;
    logic       m_wrap = 1'b0;
    logic       m_lerr = 1'b0;
    logic [1:0] m_mode = 2'b00;

    int t2421 [10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
    int t5421 [10] = '{0, 1, 2, 3, 4, 8, 9, 10, 11, 12};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
        return r;
    endfunction

    function automatic logic [W-1:0] to_code(input int v, input logic [1:0] m);
        logic [W-1:0] r;
        int d;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            d = (v / (10 ** k)) % 10;
            r[4*k +: 4] = 4'((m == 2'd0) ? d : (m == 2'd1) ? t2421[d] : (m == 2'd2) ? t5421[d] : d + 3);
        end
        return r;
    endfunction

    task automatic step(input logic r, input logic ld, input logic en, input logic up,
                        input logic [W-1:0] lv, input logic [1:0] md);
        int d;
        rst            = r;
        bus.i_load     = ld;
        bus.i_en       = en;
        bus.i_up       = up;
        bus.i_load_val = lv;
        bus.i_mode     = md;
        @(posedge clk);
        if (r) begin
            m_val = 0; m_wrap = 0; m_lerr = 0;
        end else if (ld) begin
            m_val = 0; m_wrap = 0; m_lerr = 0;
            for (int k = 0; k < ND; k++) begin
                d = int'(lv[4*k +: 4]);
                if (d > 9) begin m_lerr = 1; d = 0; end
                m_val += d * (10 ** k);
            end
        end else if (en) begin
            m_wrap = up ? (m_val == MAX - 1) : (m_val == 0);
            m_val  = up ? (m_val + 1) % MAX : (m_val + MAX - 1) % MAX;
            m_lerr = 0;
        end else begin
            m_wrap = 0; m_lerr = 0;
        end
        m_mode = md;
        #1;
        chk("count", 32'(bus.o_count), 32'(to_bcd(m_val)));
        chk("out", 32'(bus.o_out), 32'(to_code(m_val, m_mode)));
        chk("wrap", 32'(bus.o_wrap), 32'(m_wrap));
        chk("load_err", 32'(bus.o_load_err), 32'(m_lerr));
    endtask

    initial begin
        bus.i_en = 0; bus.i_up = 0; bus.i_load = 0; bus.i_load_val = '0; bus.i_mode = 0;
        step(1, 0, 0, 0, '0, 2'd1);
        chk("reset_out_2421", 32'(bus.o_out), 32'h00);
        step(1, 0, 0, 0, '0, 2'd3);
        chk("reset_out_xs3", 32'(bus.o_out), 32'h33);
        step(1, 0, 0, 0, '0, 2'd1);
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 1, 1, '0, 2'd1);
            if (i == 4) chk("d5_2421", 32'(bus.o_out), 32'h0B);
            if (i == 8) chk("d9_2421", 32'(bus.o_out), 32'h0F);
        end
        chk("wrap_up_const", 32'(bus.o_wrap), 32'd1);
        step(0, 1, 0, 0, 8'h00, 2'd0);
        step(0, 0, 1, 0, '0, 2'd0);
        chk("wrap_down_const", 32'({bus.o_wrap, bus.o_count}), 32'h199);
        step(0, 0, 1, 0, '0, 2'd0);
        chk("after_down", 32'({bus.o_wrap, bus.o_count}), 32'h098);
        step(0, 1, 0, 0, 8'h3C, 2'd2);
        chk("load_bad_const", 32'({bus.o_load_err, bus.o_count}), 32'h130);
        step(0, 1, 0, 0, 8'h47, 2'd0);
        step(0, 0, 0, 0, '0, 2'd0);
        chk("m8421", 32'(bus.o_out), 32'h47);
        step(0, 0, 0, 0, '0, 2'd1);
        chk("m2421", 32'(bus.o_out), 32'h4D);
        step(0, 0, 0, 0, '0, 2'd2);
        chk("m5421", 32'(bus.o_out), 32'h4A);
        step(0, 0, 0, 0, '0, 2'd3);
        chk("mxs3", 32'(bus.o_out), 32'h7A);
        step(0, 1, 0, 0, 8'h59, 2'd0);
        step(0, 1, 1, 1, 8'h12, 2'd0);
        chk("load_over_en", 32'(bus.o_count), 32'h12);
        step(0, 1, 0, 0, 8'h59, 2'd0);
        step(1, 1, 1, 1, 8'h12, 2'd0);
        chk("reset_over_all", 32'({bus.o_wrap, bus.o_load_err, bus.o_count}), 32'h000);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), W'($urandom), 2'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bcd_counter_multicode.md
# bcd_counter_multicode

Parametrised N-digit synchronous decade counter with selectable per-digit output code (8421, 2421 Aiken, 5421, excess-3), up/down counting, parallel load and a wrap flag. It is the general successor of the single-digit 2421 decade counter, used wherever the display and arithmetic paths need a cascaded decimal count in a chosen weighted or self-complementing code.

## Interface
- NDIGITS, 2, number of decade digits (1..8); all data buses are 4*NDIGITS bits, digit 0 in bits [3:0].
- CLK  input  1  clock; all state changes on posedge.
- RESET  input  1  synchronous, active-high reset.
- EN  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LOAD  input  1  parallel load strobe.
- LOAD_VAL  input  4*NDIGITS  BCD (8421) load value.
- MODE  input  2  output code: 00 = 8421, 01 = 2421, 10 = 5421, 11 = excess-3.
- COUNT  output  4*NDIGITS  registered counter value, always in BCD 8421.
- OUT  output  4*NDIGITS  registered encoded value, per digit in the MODE code.
- WRAP  output  1  registered, one-cycle pulse on full-range wrap.
- LOAD_ERR  output  1  registered, one-cycle pulse when a loaded digit was > 9.

## Operation
- Priority per edge: RESET > LOAD > EN > hold.
- RESET: COUNT = 0, WRAP = 0, LOAD_ERR = 0, OUT = encode(0) in the MODE sampled at that edge (0000 per digit, 0011 per digit for excess-3).
- LOAD: COUNT = LOAD_VAL with each digit > 9 replaced by 0; LOAD_ERR = 1 if any digit was > 9, else 0; WRAP = 0. EN ignored.
- EN, UP = 1: digit 0 increments; digit k increments only when digits 0..k-1 are all 9; a digit at 9 that increments becomes 0. All-9s -> all-0s with WRAP = 1.
- EN, UP = 0: digit 0 decrements; digit k decrements only when digits 0..k-1 are all 0; 0 decrements to 9. All-0s -> all-9s with WRAP = 1.
- EN = 0, no LOAD: COUNT holds; WRAP = 0, LOAD_ERR = 0.
- OUT is recomputed every edge from next-state COUNT and the MODE sampled at that edge, so OUT = encode_MODE(COUNT) holds in every cycle after the first edge.
- Codes, digit value 0..9:
  - 8421: identity.
  - 2421: 0000 0001 0010 0011 0100 1011 1100 1101 1110 1111.
  - 5421: 0000 0001 0010 0011 0100 1000 1001 1010 1011 1100.
  - excess-3: value + 3 (0011..1100).
- COUNT never holds a digit > 9.

## Timing
- Single clock domain. All outputs are registered. No combinational input-to-output path.
- Count, load and reset latency: 1 cycle. COUNT, OUT and flags all update on the same edge.
- MODE change with EN = 0: OUT re-encodes on the next edge; COUNT unchanged.
- Wrap and carry ripple resolve within one cycle for all digits. There is no multi-cycle carry.
- WRAP and LOAD_ERR are high for exactly the cycle following the causing edge. Back-to-back wraps (NDIGITS = 1, EN held) produce a WRAP pulse every 10 cycles.
- Simultaneous events:
  - RESET with LOAD or EN: reset wins.
  - LOAD with EN: the load wins and no count is applied that edge.
  - UP changing while EN is held: the new direction applies from the edge at which it is sampled.
- Reset mid-count: the next edge forces the reset values, with no partial carry.

## Test plan
- Reset, then NDIGITS = 2, MODE = 01, EN = 1, UP = 1 for 100 edges -> COUNT 00..99 then 00. OUT digit 5 = 1011 and digit 9 = 1111. WRAP high only in the cycle after the 99->00 edge.
- LOAD_VAL = 0x00, then UP = 0, EN = 1 for one edge -> COUNT = 0x99, WRAP = 1. The next edge gives 0x98 with WRAP = 0.
- LOAD_VAL = 0x3C (digit 0 = 12) -> COUNT = 0x30, LOAD_ERR = 1 for one cycle. OUT reflects 30 in the current MODE.
- COUNT = 0x47 with EN = 0; step MODE through 00, 01, 10, 11 on successive edges -> OUT = 0x47, 0x4D, 0x4A, 0x7A, with COUNT steady.
- COUNT = 0x59, EN = 1 and UP = 1, with LOAD = 1 and LOAD_VAL = 0x12 on the same edge -> COUNT = 0x12. With RESET asserted at the same time instead -> COUNT = 0x00 and all flags 0.
- Exhaustive per-digit check with NDIGITS = 1, UP = 1, all four MODEs, 20 edges each -> OUT matches the code lists above and WRAP pulses every 10th edge.
